// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-32 controller.
//   state_t      : controller state encodings (also exported on the debug port)
//   OP_*         : IR[31:26] opcode values
//   ALU_OP_*     : alu_op encodings to ALU_Control
//   SRC_B_*      : ALU B operand select encodings
//   PC_SRC_*     : PC source select encodings
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_ONE     = 2'b01;
  localparam logic [1:0] SRC_B_SIGNEXT = 2'b10;
  localparam logic [1:0] SRC_B_IMM     = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // States that hold a memory strobe and wait on mem_ready.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational output decoder for the multi-cycle controller.
// Moore outputs from state, except the mem_ready-gated enables in FETCH/MEMWR
// and the branch-qualified pc_write in BRANCH.
//   in : state, opcode, zero, mem_ready
//   out: all datapath selects/enables plus instr_done
module mc_output_decode
  import mips_mc_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        instr_done
);

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    alu_op     = ALU_OP_ADD;
    pc_src     = PC_SRC_ALU;
    instr_done = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_ONE;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRC_B_IMM;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_SIGNEXT;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_OP_SUB;
        pc_src     = PC_SRC_ALUOUT;
        instr_done = 1'b1;
        pc_write   = ((opcode == OP_BEQ) &&  zero) ||
                     ((opcode == OP_BNE) && !zero);
      end
      S_JUMP: begin
        pc_src     = PC_SRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_SIGNEXT;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS-32 controller: state register, next-state logic, memory
// watchdog and sticky error flags. Outputs are decoded in mc_output_decode.
//   in : clk, rst (async, active-high), opcode, zero, mem_ready
//   out: datapath selects/enables, instr_done, illegal, mem_timeout, state
module multicycle_controller
  import mips_mc_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned TIMEOUT   = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic        instr_done,
  output logic        illegal,
  output logic        mem_timeout,
  output logic [3:0]  state
);

  localparam logic [TIMEOUT_W:0] TIMEOUT_LIM = (TIMEOUT_W + 1)'(TIMEOUT);

  state_t                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic                   illegal_q, illegal_d;
  logic                   mem_timeout_q, mem_timeout_d;
  logic                   waiting;
  logic [TIMEOUT_W:0]     wd_next;
  logic                   wd_hit;

  always_comb begin
    state_d       = state_q;
    wd_cnt_d      = wd_cnt_q;
    illegal_d     = illegal_q;
    mem_timeout_d = mem_timeout_q;

    waiting = is_wait_state(state_q) && !mem_ready;
    // Trap fires on the wait cycle that would bring the count to TIMEOUT,
    // so at most TIMEOUT cycles are spent waiting in one state.
    wd_next = {1'b0, wd_cnt_q} + {{TIMEOUT_W{1'b0}}, 1'b1};
    wd_hit  = (TIMEOUT != 0) && waiting && (wd_next >= TIMEOUT_LIM);

    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_ADDIEX;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase

    if (wd_hit) begin
      state_d       = S_TRAP;
      mem_timeout_d = 1'b1;
    end

    // Any state change (including MEMWR -> FETCH) restarts the count.
    if (state_d != state_q) begin
      wd_cnt_d = '0;
    end else if (waiting && (wd_cnt_q != '1)) begin
      wd_cnt_d = wd_next[TIMEOUT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wd_cnt_q      <= '0;
      illegal_q     <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_cnt_q      <= wd_cnt_d;
      illegal_q     <= illegal_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  mc_output_decode u_decode (
    .state      (state_q),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .instr_done (instr_done)
  );

  assign illegal     = illegal_q;
  assign mem_timeout = mem_timeout_q;
  assign state       = state_q;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state controller that sequences a multi-cycle version of the MIPS-32 datapath: one shared memory, one ALU, and an instruction register. Each instruction is stepped through fetch, decode, execute, memory and writeback states. The controller issues every mux select and write enable. It waits on a memory-ready handshake and flags illegal opcodes and memory timeouts. It replaces the single-cycle `control_unit` when the datapath is built multi-cycle.

## Interface
Parameters:
- `TIMEOUT_W`, default 8: width of the memory-wait counter.
- `TIMEOUT`, default 200: maximum cycles spent waiting for `mem_ready` in one state. 0 disables the watchdog.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `pc_write` out 1: PC load enable (already qualified by the branch condition).
- `ir_write` out 1: IR load enable.
- `i_or_d` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` out 1 each: memory strobes.
- `reg_write` out 1: register file write enable.
- `reg_dst` out 1: write-register select. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-data select. 0 = ALUOut, 1 = MDR.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = A.
- `alu_src_b` out 2: ALU B select. 00 = B, 01 = +1, 10 = sign-extended immediate, 11 = immediate << 0 (word-addressed PC).
- `alu_op` out 2: to ALU_Control. 00 = add, 01 = sub, 10 = funct.
- `pc_src` out 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` out 1: sticky illegal-opcode flag.
- `mem_timeout` out 1: sticky watchdog flag.
- `state` out 4: current state, for debug.

## Operation
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, BNE=000101, J=000010, ADDI=001000.
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12, TRAP=15.
- Outputs are Moore, decoded from `state`. The only exceptions are the `mem_ready`-gated enables and the branch qualification. Every output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00.
  - `ir_write` and `pc_write` = `mem_ready`.
  - Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (precompute branch target).
  - LW/SW → MEMADR; R → EXEC; BEQ/BNE → BRANCH; J → JUMP; ADDI → ADDIEX; any other opcode → TRAP.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. LW → MEMRD; SW → MEMWR.
- MEMRD: `mem_read`=1, `i_or_d`=1. Wait for `mem_ready`, then go to MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. Next state FETCH.
- MEMWR: `mem_write`=1, `i_or_d`=1. Wait for `mem_ready`; in that cycle `instr_done`=1 and next state is FETCH.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next state ALUWB.
- ALUWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1. Next state FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01, `instr_done`=1.
  - `pc_write` = (BEQ & `zero`) | (BNE & !`zero`).
  - Next state FETCH.
- JUMP: `pc_src`=10, `pc_write`=1, `instr_done`=1. Next state FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1. Next state FETCH.
- TRAP: all enables 0. Stays in TRAP until `rst`. Entering from DECODE sets `illegal`; entering from the watchdog sets `mem_timeout`.
- Watchdog:
  - A counter clears on entering any wait state (FETCH, MEMRD, MEMWR).
  - It increments each cycle the controller stays in that state with `mem_ready`=0.
  - When the counter reaches `TIMEOUT` (if `TIMEOUT`≠0), the next state is TRAP and `mem_timeout` is set.
  - The counter saturates and never wraps.
- `opcode` must stay stable from DECODE through the end of the instruction. The IR is written only in FETCH, so this holds by construction.

## Timing
- Reset is asynchronous. It forces `state`=IDLE, clears the watchdog counter, `illegal` and `mem_timeout`, so every output is 0.
- The first FETCH begins on the first clock edge after `rst` deasserts.
- Latency with zero wait, in cycles: R=4, LW=5, SW=4, BEQ/BNE=3, J=3, ADDI=4. Each memory wait cycle adds 1.
- `mem_ready` is sampled at the same edge where the state advances. Strobes (`mem_read`, `mem_write`) stay high continuously until that edge.
- `rst` asserted mid-instruction aborts it immediately. No partial write completes after the reset edge.

## Structure
- Package `mips_mc_pkg` holds:
  - state encodings;
  - opcode constants;
  - `alu_op`, `alu_src_b` and `pc_src` encodings.
- Sub-module `mc_output_decode`: purely combinational, takes (`state`, `opcode`, `zero`, `mem_ready`) and drives the outputs.
- The top level holds the state register, next-state logic, watchdog counter and sticky flags.

## Test plan
- Reset, then R-type with `mem_ready` always 1:
  - states 1→2→7→8→1;
  - `reg_write`=1 and `reg_dst`=1 only in ALUWB;
  - `instr_done` pulses exactly once, 4 cycles after FETCH entry.
- LW with `mem_ready` low for 3 cycles in MEMRD:
  - 8 total cycles;
  - `mem_read` and `i_or_d`=1 held for 4 cycles;
  - `mem_to_reg`=1 in MEMWB.
- BEQ with `zero`=1 → `pc_write`=1 in BRANCH. BNE with `zero`=1 → `pc_write`=0. Both take 3 cycles.
- `opcode`=111111 → TRAP after DECODE; `illegal`=1; all enables 0 for 20+ cycles; `rst` clears the flag.
- `TIMEOUT`=5 and `mem_ready` stuck 0 in FETCH → TRAP and `mem_timeout`=1 after 5 wait cycles.
- `rst` pulsed during MEMWR while `mem_ready`=0 → `mem_write` drops asynchronously; state goes to IDLE, then FETCH.
